// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default operand width.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: diff = a - b - c_in, borrow set when the result went negative.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c_in;
  assign borrow = (~a & b) | (~a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, one bit per clock; result valid WIDTH cycles after start.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  // Minuend shifts out of the LSB while difference bits fill in from the MSB.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_diff;
  logic bit_borrow;

  full_sub u_full_sub (
    .a      (acc_q[0]),
    .b      (b_q[0]),
    .c_in   (brw_q),
    .diff   (bit_diff),
    .borrow (bit_borrow)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          acc_d   = a;
          b_d     = b;
          brw_d   = c_in;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d = {bit_diff, acc_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        brw_d = bit_borrow;
        if (cnt_q == LastBit) begin
          diff_d   = {bit_diff, acc_q[WIDTH-1:1]};
          borrow_d = bit_borrow;
`ifdef SERIAL_SUB_OVF_EN
          // brw_q is the borrow into the MSB on the last step.
          ovf_d    = brw_q ^ bit_borrow;
`endif
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      b_q      <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8) with a scoreboard of expected results.
module tb_serial_sub;

  localparam int unsigned W = 8;
  localparam int          Budget = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf    (ovf),
`endif
    .borrow (borrow)
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec);
    logic [W:0] t;
    int         s;
    exp_t       e;
    t = {1'b0, ea} - {1'b0, eb} - {{W{1'b0}}, ec};
    s = int'($signed(ea)) - int'($signed(eb)) - int'(ec);
    e.diff   = t[W-1:0];
    e.borrow = t[W];
    e.ovf    = (s > 127) || (s < -128);
    sb_q.push_back(e);
  endtask

  // Applies start for one edge; on return we sit just after capture edge E0.
  task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
    a = oa; b = ob; c_in = oc; start = 1'b1;
    step();
    start = 1'b0;
    push_exp(oa, ob, oc);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < Budget) begin
      step();
      lat++;
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: result seen with empty scoreboard (diff=%h)", name, diff);
      return;
    end
    e = sb_q.pop_front();
    n_cmp++;
    if (diff !== e.diff) begin
      n_err++;
      $display("FAIL %s diff: got %h expected %h", name, diff, e.diff);
    end
    n_cmp++;
    if (borrow !== e.borrow) begin
      n_err++;
      $display("FAIL %s borrow: got %b expected %b", name, borrow, e.borrow);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++;
    if (ovf !== e.ovf) begin
      n_err++;
      $display("FAIL %s ovf: got %b expected %b", name, ovf, e.ovf);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h01; c_in = 1'b1;
    step();
    step();
    n_cmp++;
    if ({busy, done, diff, borrow, ovf} !== '0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b diff=%h borrow=%b ovf=%b, all required 0",
               busy, done, diff, borrow, ovf);
    end
    rst = 1'b0; start = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] va[10] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [W-1:0] vb[10] = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    logic         vc[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat;
    for (int i = 6; i < 10; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      vc[i] = 1'($urandom);
    end
    for (int i = 0; i < 10; i++) begin
      start_op(va[i], vb[i], vc[i]);
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL basic%0d busy: got %b expected 1", i, busy);
      end
      wait_done(lat);
      n_cmp++;
      if (lat != W) begin
        n_err++;
        $display("FAIL basic%0d latency: got %0d expected %0d", i, lat, W);
      end
      pop_check($sformatf("basic%0d", i));
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL basic%0d return_idle: done=%b busy=%b required 0/0", i, done, busy);
      end
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] held;
    int lat;
    held = diff;
    a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
    step();
    push_exp(8'hAA, 8'h55, 1'b0);
    for (int i = 0; i < W; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || diff !== held) begin
        n_err++;
        $display("FAIL held_run%0d: busy=%b diff=%h required 1/%h", i, busy, diff, held);
      end
      if (i == 2) begin
        a = 8'h01; b = 8'hF0; c_in = 1'b1;
      end
      if (i == 5) start = 1'b0;
      step();
    end
    lat = 0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL held_done: done=%b busy=%b required 1/0", done, busy);
      wait_done(lat);
    end
    pop_check("start_held");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] prev;
    int lat;
    start_op(8'h20, 8'h03, 1'b0);
    wait_done(lat);
    pop_check("b2b_first");
    prev = diff;
    a = 8'h10; b = 8'h01; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    push_exp(8'h10, 8'h01, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_no_idle: busy=%b expected 1", busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < Budget) begin
      n_cmp++;
      if (diff !== prev) begin
        n_err++;
        $display("FAIL b2b_hold: diff=%h expected %h", diff, prev);
      end
      step();
      lat++;
    end
    n_cmp++;
    if (lat != W) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d expected %0d", lat, W);
    end
    pop_check("b2b_second");
    step();
  endtask

  task automatic test_reset_mid_run();
    exp_t dropped;
    int   pulses;
    start_op(8'h77, 8'h11, 1'b0);
    dropped = sb_q.pop_back();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, diff, borrow, ovf} !== '0) begin
      n_err++;
      $display("FAIL abort: busy=%b done=%b diff=%h borrow=%b ovf=%b, all required 0 (was %h)",
               busy, done, diff, borrow, ovf, dropped.diff);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      step();
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL abort_quiet: %0d busy/done cycles after abort, expected 0", pulses);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    test_reset();
    test_basic();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
